router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 Parameters: none; the port count (3) and address width (2) are fixed.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pkt_valid  input  1  header/payload byte valid on the input bus.
REQ-005 data_in  input  2  destination address bits of the header byte.
REQ-006 parity_done  input  1  parity byte already captured by the register block.
REQ-007 low_pkt_valid  input  1  pkt_valid fell while the selected FIFO was full.
REQ-008 fifo_full  input  1  full flag of the currently selected FIFO.
REQ-009 fifo_empty_0/1/2  input  1 each  empty flag per output FIFO.
REQ-010 soft_reset_0/1/2  input  1 each  per-port timeout soft reset.
REQ-011 detect_add, lfd_state, ld_state, laf_state, full_state  output  1 each  state decodes.
REQ-012 write_enb_reg  output  1  FIFO write request.
REQ-013 rst_int_reg  output  1  clear internal parity check.
REQ-014 busy  output  1  input-side back-pressure.

Function
REQ-015 Eight states: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR; state register updates on rising edge of clock.
REQ-016 All outputs are combinational decodes of the current state only (Moore); the next-state change is visible one cycle after the qualifying inputs.
REQ-017 addr_q (2 bits) captures data_in when state==DECODE_ADDRESS and pkt_valid==1 and data_in!=2'b11; it holds otherwise.
REQ-018 DECODE_ADDRESS: pkt_valid and data_in=N (N=0..2) and fifo_empty_N -> LOAD_FIRST_DATA; pkt_valid and data_in=N and !fifo_empty_N -> WAIT_TILL_EMPTY; data_in=2'b11 or !pkt_valid -> stay.
REQ-019 WAIT_TILL_EMPTY: fifo_empty_[addr_q] -> LOAD_FIRST_DATA; otherwise stay.
REQ-020 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-021 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full wins when both are set.
REQ-022 FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; otherwise stay.
REQ-023 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-024 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-025 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-026 soft_reset_[addr_q]==1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS, overriding REQ-018..025; soft resets of other ports are ignored.
REQ-027 Decodes: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-028 write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; 0 elsewhere.
REQ-029 busy=0 in DECODE_ADDRESS and LOAD_DATA; 1 in all other states.
REQ-030 Illegal or unreachable state encodings return to DECODE_ADDRESS on the next clock.

Reset
REQ-031 reset==1 at a rising edge sets state=DECODE_ADDRESS and addr_q=2'b00, overriding soft resets and all transitions, including mid-packet.
REQ-032 Output values after reset: detect_add=1; every other output=0.

Structure
REQ-033 Shared package router_pkg holds the state enum typedef and the constant ADDR_INVALID=2'b11.
REQ-034 The block is a single module with no sub-module: a state register plus an address register with next-state and output logic.

Verification
REQ-035 reset=1 for 2 cycles -> detect_add=1, busy=0, write_enb_reg=0.
REQ-036 pkt_valid=1, data_in=1, fifo_empty_1=1; hold pkt_valid=1 for 4 cycles, then drop it -> LOAD_FIRST_DATA for 1 cycle, then LOAD_DATA; LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), then DECODE_ADDRESS.
REQ-037 data_in=0, fifo_empty_0=0 for 5 cycles, then 1 -> WAIT_TILL_EMPTY with busy=1 for 5 cycles, then LOAD_FIRST_DATA.
REQ-038 In LOAD_DATA, fifo_full=1 for 3 cycles, then 0 with low_pkt_valid=1, parity_done=0 -> full_state=1 for 3 cycles, laf_state=1 for 1 cycle, then LOAD_PARITY.
REQ-039 addr_q=2, in FIFO_FULL_STATE: soft_reset_1=1 -> no change; soft_reset_2=1 -> DECODE_ADDRESS next cycle.
REQ-040 data_in=2'b11, pkt_valid=1 for 3 cycles -> remains in DECODE_ADDRESS and addr_q is unchanged.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the packet router control FSM.
package router_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned STATE_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Pick the per-port flag addressed by addr; the invalid address selects nothing.
  function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags,
                                    input logic [ADDR_W-1:0]    addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      2'd0:    hit = flags[0];
      2'd1:    hit = flags[1];
      2'd2:    hit = flags[2];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router input-side control FSM: header decode, FIFO load sequencing,
// full-FIFO stall handling and parity check, with per-port soft reset.
module router_fsm
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic                addr_load;
  logic [NUM_PORTS-1:0] empty_vec;
  logic [NUM_PORTS-1:0] soft_vec;
  logic                hdr_valid;
  logic                hdr_empty;
  logic                cur_empty;
  logic                cur_soft;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

  // State and latched destination address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (addr_load) begin
        addr_q <= data_in;
      end
    end
  end

  // Next-state logic; a soft reset on the active port aborts any packet in flight.
  always_comb begin
    next_state = state;
    addr_load  = 1'b0;
    hdr_valid  = pkt_valid && (data_in != ADDR_INVALID);
    hdr_empty  = port_sel(empty_vec, data_in);
    cur_empty  = port_sel(empty_vec, addr_q);
    cur_soft   = port_sel(soft_vec, addr_q);

    case (state)
      DECODE_ADDRESS: begin
        addr_load = hdr_valid;
        if (hdr_valid) begin
          next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (cur_empty) begin
          next_state = LOAD_FIRST_DATA;
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          next_state = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          next_state = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          next_state = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          next_state = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          next_state = LOAD_PARITY;
        end else begin
          next_state = LOAD_DATA;
        end
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase

    if ((state != DECODE_ADDRESS) && cur_soft) begin
      next_state = DECODE_ADDRESS;
    end
  end

  // Moore output decodes of the current state.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      WAIT_TILL_EMPTY: ;
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed and randomized checks of router_fsm against a behavioural model.
module tb_router_fsm;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int total = 0;
  int bad   = 0;

  // Model phase names (independent of the design's encoding).
  localparam int M_IDLE = 10, M_WAIT = 11, M_FIRST = 12, M_LOAD = 13,
                 M_FULL = 14, M_AFTER = 15, M_PAR = 16, M_CHK = 17;
  int       m_state;
  int       m_addr;

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] out_vec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  // Expected {detect,lfd,ld,laf,full,wr,rst_int,busy} per model phase.
  function automatic logic [7:0] exp_vec(input int s);
    case (s)
      M_IDLE:  return 8'b1000_0000;
      M_WAIT:  return 8'b0000_0001;
      M_FIRST: return 8'b0100_0001;
      M_LOAD:  return 8'b0010_0100;
      M_FULL:  return 8'b0000_1001;
      M_AFTER: return 8'b0001_0101;
      M_PAR:   return 8'b0000_0101;
      M_CHK:   return 8'b0000_0011;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic port_empty(input int a);
    logic [2:0] e;
    e = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    return (a < 3) ? e[a] : 1'b0;
  endfunction

  function automatic logic port_soft(input int a);
    logic [2:0] s;
    s = {soft_reset_2, soft_reset_1, soft_reset_0};
    return (a < 3) ? s[a] : 1'b0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int ns;
    int din;
    din = int'(data_in);
    ns  = m_state;
    if (reset) begin
      m_state = M_IDLE;
      m_addr  = 0;
      return;
    end
    if (m_state != M_IDLE && port_soft(m_addr)) begin
      ns = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE:  if (pkt_valid && din != 3) ns = port_empty(din) ? M_FIRST : M_WAIT;
        M_WAIT:  if (port_empty(m_addr)) ns = M_FIRST;
        M_FIRST: ns = M_LOAD;
        M_LOAD:  ns = fifo_full ? M_FULL : (!pkt_valid ? M_PAR : M_LOAD);
        M_FULL:  if (!fifo_full) ns = M_AFTER;
        M_AFTER: ns = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_LOAD);
        M_PAR:   ns = M_CHK;
        M_CHK:   ns = fifo_full ? M_FULL : M_IDLE;
        default: ns = M_IDLE;
      endcase
    end
    if (m_state == M_IDLE && pkt_valid && din != 3) m_addr = din;
    m_state = ns;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: update model at the edge, sample #1 later and compare.
  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check({tag, "/model"}, out_vec(), exp_vec(m_state));
  endtask

  task automatic check_addr(input string tag);
    check(tag, {6'b0, dut.addr_q}, 8'(m_addr));
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
    fifo_empty_0 = 0; fifo_empty_1 = 0; fifo_empty_2 = 0;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    m_state = M_IDLE; m_addr = 0;

    // Reset held for two cycles.
    tick("rst0"); tick("rst1");
    check("rst_detect", {7'b0, detect_add}, 8'd1);
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_wr", {7'b0, write_enb_reg}, 8'd0);
    check("rst_all", out_vec(), 8'b1000_0000);
    check_addr("rst_addr");
    @(negedge clock); reset = 0;

    // Normal packet to port 1.
    pkt_valid = 1; data_in = 2'd1; fifo_empty_1 = 1;
    tick("p1_lfd");
    check("p1_lfd", {7'b0, lfd_state}, 8'd1);
    tick("p1_ld0");
    check("p1_ld", {7'b0, ld_state}, 8'd1);
    tick("p1_ld1"); tick("p1_ld2");
    pkt_valid = 0;
    tick("p1_par");
    check("p1_par_wr", out_vec(), 8'b0000_0101);
    tick("p1_chk");
    check("p1_rst_int", {7'b0, rst_int_reg}, 8'd1);
    tick("p1_idle");
    check("p1_idle", {7'b0, detect_add}, 8'd1);
    check_addr("p1_addr");

    // Wait for port 0 to drain.
    pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick("w_wait");
      check("w_busy", out_vec(), 8'b0000_0001);
      pkt_valid = 0;
    end
    fifo_empty_0 = 1;
    tick("w_lfd");
    check("w_lfd", {7'b0, lfd_state}, 8'd1);
    pkt_valid = 1;
    tick("w_ld");

    // Full stall then late parity.
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      tick("f_full");
      check("f_full", {7'b0, full_state}, 8'd1);
    end
    fifo_full = 0; low_pkt_valid = 1; parity_done = 0;
    tick("f_laf");
    check("f_laf", {7'b0, laf_state}, 8'd1);
    tick("f_par");
    check("f_par", out_vec(), 8'b0000_0101);
    low_pkt_valid = 0;
    tick("f_chk"); tick("f_idle");

    // Soft reset only honoured for the active port.
    data_in = 2'd2; fifo_empty_2 = 1; pkt_valid = 1;
    tick("s_lfd"); tick("s_ld");
    fifo_full = 1;
    tick("s_full");
    soft_reset_1 = 1;
    tick("s_other");
    check("s_other_ignored", {7'b0, full_state}, 8'd1);
    soft_reset_1 = 0; soft_reset_2 = 1;
    tick("s_own");
    check("s_own_abort", {7'b0, detect_add}, 8'd1);
    check_addr("s_addr2");
    soft_reset_2 = 0; fifo_full = 0;

    // Invalid header address is ignored.
    data_in = 2'b11; pkt_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick("inv");
      check("inv_stay", {7'b0, detect_add}, 8'd1);
      check_addr("inv_addr");
    end

    // Mid-packet synchronous reset.
    data_in = 2'd0;
    tick("m_lfd"); tick("m_ld");
    reset = 1;
    tick("m_rst");
    check("m_rst_state", out_vec(), 8'b1000_0000);
    check_addr("m_rst_addr");
    reset = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 19) == 0);
      soft_reset_1  = ($urandom_range(0, 19) == 0);
      soft_reset_2  = ($urandom_range(0, 19) == 0);
      tick("rand");
      check_addr("rand_addr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
